dca_lpixm_axi_bridge: RTL and testbench

- Downstream neighbour of the DCA matrix LSU's single-port LPIXM master.
- Converts the merged slxq request stream (read or write bursts) into AXI4 AR/R and AW/W/B channels.
- Returns read data beats and one write-reply beat on the slxy stream.
- One transaction outstanding; fixed AXI ID 0.

---
 rtl/dca_lpixm_axi_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_dca_lpixm_axi_bridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dca_lpixm_axi_bridge.sv
// dca_lpixm_axi_bridge
//   Converts the LSU's merged slxq request stream into AXI4 AR/R and
//   AW/W/B traffic and returns replies on the slxy stream. One transaction
//   is in flight at a time and the AXI ID is fixed at 0 (ports tied outside).
//
//   Optional feature: define DCA_LPIXM_AXI_BRIDGE_LENCHECK_EN to count write
//   beats, generate wlast from the count and flag a sticky len_error when the
//   upstream slxqlast disagrees with the count.
module dca_lpixm_axi_bridge #(
  parameter int BW_AXI_ADDR   = 32,
  parameter int BW_AXI_DATA   = 32,
  parameter int BW_LPI_BURDEN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  // request stream
  input  logic                       slxqvalid,
  input  logic                       slxqlast,
  input  logic                       slxqwrite,
  input  logic [7:0]                 slxqlen,
  input  logic [2:0]                 slxqsize,
  input  logic [1:0]                 slxqburst,
  input  logic [BW_AXI_DATA/8-1:0]   slxqwstrb,
  input  logic [BW_AXI_DATA-1:0]     slxqwdata,
  input  logic [BW_AXI_ADDR-1:0]     slxqaddr,
  input  logic [BW_LPI_BURDEN-1:0]   slxqburden,
  output logic [1:0]                 slxqdready,
  // reply stream
  output logic                       slxyvalid,
  output logic                       slxylast,
  output logic                       slxywreply,
  output logic [1:0]                 slxyresp,
  output logic [BW_AXI_DATA-1:0]     slxyrdata,
  output logic [BW_LPI_BURDEN-1:0]   slxyburden,
  input  logic [1:0]                 slxydready,
  // AXI write address
  output logic [BW_AXI_ADDR-1:0]     awaddr,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic                       awvalid,
  input  logic                       awready,
  // AXI write data
  output logic [BW_AXI_DATA-1:0]     wdata,
  output logic [BW_AXI_DATA/8-1:0]   wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  // AXI write response
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready,
  // AXI read address
  output logic [BW_AXI_ADDR-1:0]     araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  // AXI read data
  input  logic [BW_AXI_DATA-1:0]     rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
`ifdef DCA_LPIXM_AXI_BRIDGE_LENCHECK_EN
  output logic                       len_error,
`endif
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_RDATA,
    S_AW,
    S_WDATA,
    S_BRESP
  } state_t;

  state_t                     state;
  logic [BW_LPI_BURDEN-1:0]   burden_q;
  logic                       w_fire;
  logic                       w_last_beat;

  // Lookahead bit of the reply-side ready is reserved and deliberately ignored.
  logic unused_dready_hi;
  assign unused_dready_hi = slxydready[1];

  assign busy   = (state != S_IDLE);
  assign w_fire = (state == S_WDATA) && slxqvalid && wready;

`ifdef DCA_LPIXM_AXI_BRIDGE_LENCHECK_EN
  logic [7:0] wcount;

  assign w_last_beat = (wcount == awlen);

  // Count accepted W beats and latch any slxqlast/count disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcount    <= 8'd0;
      len_error <= 1'b0;
    end else begin
      if ((state == S_AW) && awready)
        wcount <= 8'd0;
      else if (w_fire)
        wcount <= wcount + 8'd1;
      if (w_fire && (slxqlast != w_last_beat))
        len_error <= 1'b1;
    end
  end
`else
  assign w_last_beat = slxqlast;
`endif

  // Transaction FSM with registered AXI address channels and captured burden.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the captured address/burden registers are cleared as well so
      // the AXI address buses read 0 out of reset, not just the valids.
      state    <= S_IDLE;
      burden_q <= '0;
      awaddr   <= '0;
      awlen    <= 8'd0;
      awsize   <= 3'd0;
      awburst  <= 2'd0;
      awvalid  <= 1'b0;
      araddr   <= '0;
      arlen    <= 8'd0;
      arsize   <= 3'd0;
      arburst  <= 2'd0;
      arvalid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (slxqvalid) begin
            burden_q <= slxqburden;
            if (slxqwrite) begin
              awaddr  <= slxqaddr;
              awlen   <= slxqlen;
              awsize  <= slxqsize;
              awburst <= slxqburst;
              awvalid <= 1'b1;
              state   <= S_AW;
            end else begin
              araddr  <= slxqaddr;
              arlen   <= slxqlen;
              arsize  <= slxqsize;
              arburst <= slxqburst;
              arvalid <= 1'b1;
              state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (rvalid && rready && rlast)
            state <= S_IDLE;
        end
        S_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            state   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (w_fire && w_last_beat)
            state <= S_BRESP;
        end
        S_BRESP: begin
          if (bvalid && bready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Zero-latency pass-through of W, R and B handshakes, selected by state.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    slxqdready = 2'b00;
    slxyvalid  = 1'b0;
    slxylast   = 1'b0;
    slxywreply = 1'b0;
    slxyresp   = 2'b00;
    slxyrdata  = '0;
    slxyburden = '0;
    wdata      = '0;
    wstrb      = '0;
    wlast      = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    rready     = 1'b0;
    case (state)
      S_AR: begin
        // The single read request beat is consumed on the AR handshake.
        slxqdready = {2{arready}};
      end
      S_RDATA: begin
        slxyvalid  = rvalid;
        rready     = slxydready[0];
        slxyrdata  = rdata;
        slxyresp   = rresp;
        slxylast   = rlast;
        slxyburden = burden_q;
      end
      S_WDATA: begin
        wvalid     = slxqvalid;
        slxqdready = {2{wready}};
        wdata      = slxqwdata;
        wstrb      = slxqwstrb;
        wlast      = w_last_beat;
      end
      S_BRESP: begin
        slxyvalid  = bvalid;
        bready     = slxydready[0];
        slxywreply = 1'b1;
        slxylast   = 1'b1;
        slxyresp   = bresp;
        slxyburden = burden_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dca_lpixm_axi_bridge.sv
// tb_dca_lpixm_axi_bridge
//   Directed bench for dca_lpixm_axi_bridge. The bench plays both the LSU
//   upstream and the AXI slave; inputs change on the falling edge and
//   outputs are sampled 1 ns later. Define DCA_LPIXM_AXI_BRIDGE_LENCHECK_EN
//   to also exercise the write length checker.
module tb_dca_lpixm_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        slxqvalid, slxqlast, slxqwrite;
  logic [7:0]  slxqlen;
  logic [2:0]  slxqsize;
  logic [1:0]  slxqburst;
  logic [3:0]  slxqwstrb;
  logic [31:0] slxqwdata, slxqaddr;
  logic [0:0]  slxqburden;
  logic [1:0]  slxqdready;
  logic        slxyvalid, slxylast, slxywreply;
  logic [1:0]  slxyresp;
  logic [31:0] slxyrdata;
  logic [0:0]  slxyburden;
  logic [1:0]  slxydready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        busy;
`ifdef DCA_LPIXM_AXI_BRIDGE_LENCHECK_EN
  logic        len_error;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dca_lpixm_axi_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .slxqvalid  (slxqvalid),
    .slxqlast   (slxqlast),
    .slxqwrite  (slxqwrite),
    .slxqlen    (slxqlen),
    .slxqsize   (slxqsize),
    .slxqburst  (slxqburst),
    .slxqwstrb  (slxqwstrb),
    .slxqwdata  (slxqwdata),
    .slxqaddr   (slxqaddr),
    .slxqburden (slxqburden),
    .slxqdready (slxqdready),
    .slxyvalid  (slxyvalid),
    .slxylast   (slxylast),
    .slxywreply (slxywreply),
    .slxyresp   (slxyresp),
    .slxyrdata  (slxyrdata),
    .slxyburden (slxyburden),
    .slxydready (slxydready),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .awsize     (awsize),
    .awburst    (awburst),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wlast      (wlast),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready),
`ifdef DCA_LPIXM_AXI_BRIDGE_LENCHECK_EN
    .len_error  (len_error),
`endif
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read of len+1 beats; slave returns addr+i. stall_beat: consumer holds
  // off 3 cycles before that beat; err_beat: that beat carries SLVERR.
  task automatic do_read(input logic [31:0] addr, input int len, input logic bd,
                         input int ar_wait, input int stall_beat, input int err_beat);
    @(negedge clk);
    slxqvalid = 1'b1; slxqwrite = 1'b0; slxqaddr = addr; slxqlen = 8'(len);
    slxqsize = 3'd2; slxqburst = 2'b01; slxqlast = 1'b1; slxqburden = bd;
    #1;
    check("rd_idle_dready", slxqdready, 0);
    check("rd_idle_arvalid", arvalid, 0);
    @(negedge clk); #1;
    check("rd_arvalid", arvalid, 1);
    check("rd_araddr", araddr, addr);
    check("rd_arlen", arlen, len);
    check("rd_arsize", arsize, 2);
    check("rd_arburst", arburst, 1);
    check("rd_busy", busy, 1);
    for (int k = 0; k < ar_wait; k++) begin
      @(negedge clk); #1;
      check("rd_arvalid_hold", arvalid, 1);
      check("rd_araddr_hold", araddr, addr);
      check("rd_dready_wait", slxqdready, 0);
    end
    arready = 1'b1; #1;
    check("rd_consume", slxqdready, 2'b11);
    @(negedge clk);
    arready = 1'b0; slxqvalid = 1'b0; #1;
    check("rd_arvalid_drop", arvalid, 0);
    check("rd_dready_after", slxqdready, 0);
    for (int i = 0; i <= len; i++) begin
      rvalid = 1'b1; rdata = addr + 32'(i);
      rresp = (i == err_beat) ? 2'd2 : 2'd0; rlast = (i == len);
      if (i == stall_beat) begin
        for (int s = 0; s < 3; s++) begin
          slxydready = 2'b10; #1;
          check("rd_stall_valid", slxyvalid, 1);
          check("rd_stall_rready", rready, 0);
          @(negedge clk);
        end
      end
      slxydready = 2'b01; #1;
      check("rd_beat_valid", slxyvalid, 1);
      check("rd_beat_rready", rready, 1);
      check("rd_beat_data", slxyrdata, addr + 32'(i));
      check("rd_beat_resp", slxyresp, (i == err_beat) ? 2 : 0);
      check("rd_beat_last", slxylast, (i == len) ? 1 : 0);
      check("rd_beat_wreply", slxywreply, 0);
      check("rd_beat_burden", slxyburden, bd);
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0; slxydready = 2'b00; #1;
    check("rd_busy_end", busy, 0);
    check("rd_slxyvalid_end", slxyvalid, 0);
  endtask

  // Write of len+1 beats of data base+i; slxqlast is driven on beat last_at.
  task automatic do_write(input logic [31:0] addr, input int len, input logic bd,
                          input int aw_wait, input bit toggle, input int last_at,
                          input logic [31:0] base, input logic [1:0] br, input int b_stall);
    int  i, end_i, guard;
    bit  tog;
    logic exp_last;
`ifdef DCA_LPIXM_AXI_BRIDGE_LENCHECK_EN
    end_i = len;
`else
    end_i = last_at;
`endif
    @(negedge clk);
    slxqvalid = 1'b1; slxqwrite = 1'b1; slxqaddr = addr; slxqlen = 8'(len);
    slxqsize = 3'd2; slxqburst = 2'b01; slxqwdata = base; slxqwstrb = 4'hF;
    slxqlast = (last_at == 0); slxqburden = bd;
    #1;
    check("wr_idle_dready", slxqdready, 0);
    @(negedge clk); #1;
    check("wr_awvalid", awvalid, 1);
    check("wr_awaddr", awaddr, addr);
    check("wr_awlen", awlen, len);
    check("wr_no_early_w", wvalid, 0);
    for (int k = 0; k < aw_wait; k++) begin
      @(negedge clk); #1;
      check("wr_awvalid_hold", awvalid, 1);
      check("wr_awaddr_hold", awaddr, addr);
      check("wr_no_early_w_wait", wvalid, 0);
    end
    awready = 1'b1; #1;
    check("wr_aw_no_consume", slxqdready, 0);
    @(negedge clk);
    awready = 1'b0; #1;
    check("wr_awvalid_drop", awvalid, 0);
    i = 0; tog = 1'b0; guard = 0;
    while (i <= end_i && guard < 64) begin
      slxqvalid = 1'b1; slxqwdata = base + 32'(i); slxqlast = (i == last_at);
      wready = toggle ? tog : 1'b1;
      exp_last = (i == end_i);
      #1;
      check("wr_wvalid", wvalid, 1);
      check("wr_wdata", wdata, base + 32'(i));
      check("wr_wstrb", wstrb, 4'hF);
      check("wr_wlast", wlast, exp_last);
      check("wr_dready", slxqdready[0], wready);
      if (wready) i++;
      tog = ~tog; guard++;
      @(negedge clk);
    end
    if (guard >= 64) check("wr_beat_timeout", 1, 0);
    slxqvalid = 1'b0; wready = 1'b0; slxqlast = 1'b0; #1;
    check("wr_wvalid_end", wvalid, 0);
    check("wr_bwait_valid", slxyvalid, 0);
    bvalid = 1'b1; bresp = br;
    for (int s = 0; s < b_stall; s++) begin
      slxydready = 2'b00; #1;
      check("wr_bstall_valid", slxyvalid, 1);
      check("wr_bstall_bready", bready, 0);
      @(negedge clk);
    end
    slxydready = 2'b01; #1;
    check("wr_reply_valid", slxyvalid, 1);
    check("wr_reply_bready", bready, 1);
    check("wr_reply_wreply", slxywreply, 1);
    check("wr_reply_last", slxylast, 1);
    check("wr_reply_resp", slxyresp, br);
    check("wr_reply_rdata", slxyrdata, 0);
    check("wr_reply_burden", slxyburden, bd);
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'd0; slxydready = 2'b00; #1;
    check("wr_busy_end", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    slxqvalid = 0; slxqlast = 0; slxqwrite = 0; slxqlen = 0; slxqsize = 0;
    slxqburst = 0; slxqwstrb = 0; slxqwdata = 0; slxqaddr = 0; slxqburden = 0;
    slxydready = 0; awready = 0; wready = 0; bresp = 0; bvalid = 0;
    arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_slxyvalid", slxyvalid, 0);
    check("rst_dready", slxqdready, 0);
    check("rst_araddr", araddr, 0);
    check("rst_awaddr", awaddr, 0);
`ifdef DCA_LPIXM_AXI_BRIDGE_LENCHECK_EN
    check("rst_len_error", len_error, 0);
`endif
    rst = 1'b0;

    // Basic read and write
    do_read(32'h1000, 3, 1'b1, 0, -1, -1);
    do_write(32'h2000, 1, 1'b0, 0, 1'b0, 1, 32'hA, 2'd0, 0);

    // Backpressure on every channel
    do_read(32'h3000, 2, 1'b0, 5, 1, -1);
    do_write(32'h4000, 3, 1'b1, 5, 1'b1, 3, 32'h40, 2'd0, 3);

    // Reset after 1 of 4 write beats
    @(negedge clk);
    slxqvalid = 1'b1; slxqwrite = 1'b1; slxqaddr = 32'h7000; slxqlen = 8'd3;
    slxqwdata = 32'h70; slxqwstrb = 4'hF; slxqlast = 1'b0;
    @(negedge clk);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b1; #1;
    check("rsw_wvalid", wvalid, 1);
    @(negedge clk);
    slxqwdata = 32'h71; rst = 1'b1;
    @(negedge clk); #1;
    check("rsw_wvalid", wvalid, 0);
    check("rsw_awvalid", awvalid, 0);
    check("rsw_arvalid", arvalid, 0);
    check("rsw_slxyvalid", slxyvalid, 0);
    check("rsw_busy", busy, 0);
    check("rsw_dready", slxqdready, 0);
    rst = 1'b0; slxqvalid = 1'b0; wready = 1'b0;
    do_read(32'h5000, 0, 1'b1, 0, -1, -1);

    // SLVERR propagation
    do_write(32'h6000, 0, 1'b0, 1, 1'b0, 0, 32'h60, 2'd2, 0);
    do_read(32'h6100, 3, 1'b0, 0, -1, 1);

`ifdef DCA_LPIXM_AXI_BRIDGE_LENCHECK_EN
    // Early slxqlast on beat 2 of 3: wlast still on beat 3, error sticky
    check("lc_clean", len_error, 0);
    do_write(32'h8000, 2, 1'b1, 0, 1'b0, 1, 32'h80, 2'd0, 0);
    check("lc_error_set", len_error, 1);
    do_read(32'h8100, 1, 1'b0, 0, -1, -1);
    check("lc_error_held", len_error, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("lc_error_cleared", len_error, 0);
    rst = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
